// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and memory-side signals around mem_arbiter.
interface mem_arbiter_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    // Fetch requester
    logic              f_req_i;
    logic [AWIDTH-1:0] f_addr_i;
    logic              f_gnt_o;
    logic              f_rsp_vld_o;
    logic [DWIDTH-1:0] f_rsp_data_o;

    // Load/store requester
    logic              d_req_i;
    logic              d_we_i;
    logic [AWIDTH-1:0] d_addr_i;
    logic [DWIDTH-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rsp_vld_o;
    logic [DWIDTH-1:0] d_rsp_data_o;

    // Shared response qualifier
    logic              rsp_err_o;

    // Memory side
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [DWIDTH-1:0] mem_data_i;
    logic              mem_data_vld_i;

    // Status
    logic              busy_o;

    // Arbiter side
    modport slave (
        input  f_req_i, f_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_data_i, mem_data_vld_i,
        output f_gnt_o, f_rsp_vld_o, f_rsp_data_o,
        output d_gnt_o, d_rsp_vld_o, d_rsp_data_o,
        output rsp_err_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
        output busy_o
    );

    // Requesters and memory side
    modport master (
        output f_req_i, f_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_data_i, mem_data_vld_i,
        input  f_gnt_o, f_rsp_vld_o, f_rsp_data_o,
        input  d_gnt_o, d_rsp_vld_o, d_rsp_data_o,
        input  rsp_err_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
        input  busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data requests win, a streak limit lets a
// waiting fetch in, each access runs grant -> ACCESS -> registered response.
module mem_arbiter #(
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e            state_q,      state_d;
    logic              owner_q,      owner_d;       // 1 = data requester
    logic              we_q,         we_d;
    logic [AWIDTH-1:0] addr_q,       addr_d;
    logic [DWIDTH-1:0] wdata_q,      wdata_d;
    logic              rd_en_q,      rd_en_d;
    logic              wr_en_q,      wr_en_d;
    logic [SW-1:0]     streak_q,     streak_d;
    logic [TW-1:0]     tcnt_q,       tcnt_d;
    logic              f_rsp_vld_q,  f_rsp_vld_d;
    logic              d_rsp_vld_q,  d_rsp_vld_d;
    logic [DWIDTH-1:0] f_rsp_data_q, f_rsp_data_d;
    logic [DWIDTH-1:0] d_rsp_data_q, d_rsp_data_d;
    logic              rsp_err_q,    rsp_err_d;

    logic              f_gnt_c;
    logic              d_gnt_c;
    logic              exit_c;
    logic              err_c;
    logic [DWIDTH-1:0] rdata_c;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            streak_q     <= '0;
            tcnt_q       <= '0;
            f_rsp_vld_q  <= 1'b0;
            d_rsp_vld_q  <= 1'b0;
            f_rsp_data_q <= '0;
            d_rsp_data_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            streak_q     <= streak_d;
            tcnt_q       <= tcnt_d;
            f_rsp_vld_q  <= f_rsp_vld_d;
            d_rsp_vld_q  <= d_rsp_vld_d;
            f_rsp_data_q <= f_rsp_data_d;
            d_rsp_data_q <= d_rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Arbitration, access sequencing, timeout and response generation
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        streak_d     = streak_q;
        tcnt_d       = tcnt_q;
        f_rsp_vld_d  = 1'b0;
        d_rsp_vld_d  = 1'b0;
        f_rsp_data_d = '0;
        d_rsp_data_d = '0;
        rsp_err_d    = 1'b0;
        f_gnt_c      = 1'b0;
        d_gnt_c      = 1'b0;
        exit_c       = 1'b0;
        err_c        = 1'b0;
        rdata_c      = '0;

        case (state_q)
            IDLE: begin
                // Grants are suppressed while reset is held
                if (rst) begin
                    if (bus.d_req_i && (!bus.f_req_i || streak_q != STREAK_MAX)) begin
                        d_gnt_c = 1'b1;
                    end else if (bus.f_req_i) begin
                        f_gnt_c = 1'b1;
                    end
                end

                if (!bus.f_req_i || f_gnt_c) begin
                    streak_d = '0;
                end else if (d_gnt_c && streak_q != STREAK_MAX) begin
                    streak_d = streak_q + SW'(1);
                end

                if (d_gnt_c || f_gnt_c) begin
                    state_d = ACCESS;
                    owner_d = d_gnt_c;
                    we_d    = d_gnt_c & bus.d_we_i;
                    addr_d  = d_gnt_c ? bus.d_addr_i : bus.f_addr_i;
                    wdata_d = d_gnt_c ? bus.d_wdata_i : '0;
                    rd_en_d = !(d_gnt_c & bus.d_we_i);
                    wr_en_d = d_gnt_c & bus.d_we_i;
                    tcnt_d  = '0;
                end
            end

            ACCESS: begin
                // Writes finish after one cycle; reads wait for valid or timeout
                if (we_q) begin
                    exit_c = 1'b1;
                end else if (bus.mem_data_vld_i) begin
                    exit_c  = 1'b1;
                    rdata_c = bus.mem_data_i;
                end else if (tcnt_q == TCNT_LAST) begin
                    exit_c = 1'b1;
                    err_c  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end

                if (exit_c) begin
                    state_d      = IDLE;
                    we_d         = 1'b0;
                    addr_d       = '0;
                    wdata_d      = '0;
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    tcnt_d       = '0;
                    f_rsp_vld_d  = !owner_q;
                    d_rsp_vld_d  = owner_q;
                    f_rsp_data_d = owner_q ? '0 : rdata_c;
                    d_rsp_data_d = owner_q ? rdata_c : '0;
                    rsp_err_d    = err_c;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.f_gnt_o        = f_gnt_c;
    assign bus.d_gnt_o        = d_gnt_c;
    assign bus.f_rsp_vld_o    = f_rsp_vld_q;
    assign bus.d_rsp_vld_o    = d_rsp_vld_q;
    assign bus.f_rsp_data_o   = f_rsp_data_q;
    assign bus.d_rsp_data_o   = d_rsp_data_q;
    assign bus.rsp_err_o      = rsp_err_q;
    assign bus.mem_addr_o     = addr_q;
    assign bus.mem_data_o     = wdata_q;
    assign bus.mem_read_en_o  = rd_en_q;
    assign bus.mem_write_en_o = wr_en_q;
    assign bus.busy_o         = (state_q == ACCESS);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grants, access windows and responses.
module tb_mem_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXS = 4;
    localparam int unsigned TO   = 16;
    localparam int unsigned OW   = 8 + 3 * DW + AW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cur_lat = 0;
    int   rd_cycles = 0;

    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    mem_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Contents of a never-written location
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return DW'(a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'(32'h0100_0000 | ($urandom_range(0, 7) << 2));
    endfunction

    function automatic int pick_lat();
        int s;
        s = int'($urandom_range(0, 9));
        if (s < 6)  return int'($urandom_range(0, 3));
        if (s == 6) return int'(TO) - 1;
        if (s == 7) return int'(TO);
        if (s == 8) return 100;
        return int'($urandom_range(4, 14));
    endfunction

    function automatic logic [OW-1:0] outs();
        return {bus.f_gnt_o, bus.d_gnt_o, bus.f_rsp_vld_o, bus.d_rsp_vld_o,
                bus.rsp_err_o, bus.mem_read_en_o, bus.mem_write_en_o, bus.busy_o,
                bus.f_rsp_data_o, bus.d_rsp_data_o, bus.mem_addr_o, bus.mem_data_o};
    endfunction

    // Memory model: responds cur_lat cycles into a read window
    task automatic mem_drive();
        if (bus.mem_write_en_o) mem_arr[bus.mem_addr_o] = bus.mem_data_o;
        if (bus.mem_read_en_o) begin
            if (rd_cycles == cur_lat) begin
                bus.mem_data_vld_i = 1'b1;
                bus.mem_data_i = mem_arr.exists(bus.mem_addr_o) ? mem_arr[bus.mem_addr_o]
                                                                 : fill(bus.mem_addr_o);
            end else begin
                bus.mem_data_vld_i = 1'b0;
                bus.mem_data_i = DW'($urandom);
            end
            rd_cycles++;
        end else begin
            rd_cycles = 0;
            bus.mem_data_vld_i = 1'b0;
            bus.mem_data_i = DW'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic idle_inputs();
        bus.f_req_i   = 1'b0;
        bus.f_addr_i  = '0;
        bus.d_req_i   = 1'b0;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = '0;
        bus.d_wdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.f_req_i   = 1'b1;
        bus.f_addr_i  = 32'h0100_0010;
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = 32'h0100_0020;
        bus.d_wdata_i = 32'h1111_2222;
        cur_lat = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (outs() !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, outs());
            end
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.d_gnt_o, bus.f_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant: got d/f=%b expected 10", {bus.d_gnt_o, bus.f_gnt_o});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        do_reset();
        cur_lat = 0;
        mem_arr[32'h0100_0000] = 32'h0000_0013;
        tick();
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'h0100_0000;
        #1;
        checks++;
        if ({bus.f_gnt_o, bus.d_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_grant: got f/d=%b expected 10", {bus.f_gnt_o, bus.d_gnt_o});
        end
        tick();
        bus.f_req_i = 1'b0;
        #1;
        checks++;
        if ({bus.mem_read_en_o, bus.mem_write_en_o, bus.busy_o, bus.mem_addr_o} !== {3'b101, 32'h0100_0000}) begin
            errors++;
            $display("FAIL fetch_access: got rd/wr/busy=%b addr=%h expected 101 01000000",
                     {bus.mem_read_en_o, bus.mem_write_en_o, bus.busy_o}, bus.mem_addr_o);
        end
        tick();
        #1;
        checks++;
        if ({bus.f_rsp_vld_o, bus.d_rsp_vld_o, bus.rsp_err_o, bus.f_rsp_data_o} !== {3'b100, 32'h0000_0013}) begin
            errors++;
            $display("FAIL fetch_response: got vld f/d/err=%b data=%h expected 100 00000013",
                     {bus.f_rsp_vld_o, bus.d_rsp_vld_o, bus.rsp_err_o}, bus.f_rsp_data_o);
        end
    endtask

    task automatic test_store_load();
        int t0;
        bit got;
        do_reset();
        cur_lat = 2;
        tick();
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 32'h0100_0040;
        bus.d_wdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.d_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL store_grant: got %b expected 1", bus.d_gnt_o);
        end
        tick();
        bus.d_req_i = 1'b0;
        #1;
        checks++;
        if ({bus.mem_write_en_o, bus.mem_read_en_o, bus.mem_addr_o, bus.mem_data_o} !== {2'b10, 32'h0100_0040, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_access: got wr/rd=%b addr=%h data=%h expected 10 01000040 deadbeef",
                     {bus.mem_write_en_o, bus.mem_read_en_o}, bus.mem_addr_o, bus.mem_data_o);
        end
        tick();
        #1;
        checks++;
        if ({bus.d_rsp_vld_o, bus.rsp_err_o, bus.mem_write_en_o, bus.d_rsp_data_o} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL store_ack: got vld/err/wr=%b data=%h expected 100 00000000",
                     {bus.d_rsp_vld_o, bus.rsp_err_o, bus.mem_write_en_o}, bus.d_rsp_data_o);
        end
        tick();
        bus.d_req_i = 1'b1;
        bus.d_we_i  = 1'b0;
        #1;
        checks++;
        if (bus.d_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL load_grant: got %b expected 1", bus.d_gnt_o);
        end
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.d_req_i = 1'b0;
            #1;
            if (bus.d_rsp_vld_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || (cyc - t0) != 4 || bus.d_rsp_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_after_store: got vld=%b latency=%0d data=%h expected 1 4 deadbeef",
                     got, cyc - t0, bus.d_rsp_data_o);
        end
    endtask

    task automatic test_contention();
        logic got_d [10];
        int   ng;
        logic exp_d;
        do_reset();
        cur_lat = 0;
        ng = 0;
        bus.f_addr_i = 32'h0100_0004;
        bus.d_addr_i = 32'h0100_0008;
        bus.d_we_i   = 1'b0;
        for (int i = 0; i < 60 && ng < 10; i++) begin
            tick();
            bus.f_req_i = 1'b1;
            bus.d_req_i = 1'b1;
            #1;
            checks++;
            if (bus.f_gnt_o && bus.d_gnt_o) begin
                errors++;
                $display("FAIL double_grant at cycle %0d: got f/d=11 expected at most one", cyc);
            end
            if (bus.f_gnt_o || bus.d_gnt_o) begin
                got_d[ng] = bus.d_gnt_o;
                ng++;
            end
        end
        checks++;
        if (ng != 10) begin
            errors++;
            $display("FAIL contention_grant_count: got %0d expected 10", ng);
        end
        for (int k = 0; k < ng; k++) begin
            exp_d = ((k % 5) != 4);
            checks++;
            if (got_d[k] !== exp_d) begin
                errors++;
                $display("FAIL contention_order grant%0d: got data=%b expected %b", k, got_d[k], exp_d);
            end
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int t0;
        bit got;
        do_reset();
        cur_lat = 1000;
        tick();
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h0100_0080;
        #1;
        checks++;
        if (bus.d_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_grant: got %b expected 1", bus.d_gnt_o);
        end
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            bus.d_req_i = 1'b0;
            #1;
            if (bus.d_rsp_vld_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || (cyc - t0) != int'(TO) + 1 || bus.rsp_err_o !== 1'b1 || bus.d_rsp_data_o !== 32'h0) begin
            errors++;
            $display("FAIL timeout_response: got vld=%b latency=%0d err=%b data=%h expected 1 %0d 1 00000000",
                     got, cyc - t0, bus.rsp_err_o, bus.d_rsp_data_o, TO + 1);
        end
        cur_lat = 1;
        mem_arr[32'h0100_0100] = 32'h1234_5678;
        tick();
        bus.f_req_i  = 1'b1;
        bus.f_addr_i = 32'h0100_0100;
        #1;
        checks++;
        if (bus.f_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL resume_grant: got %b expected 1", bus.f_gnt_o);
        end
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.f_req_i = 1'b0;
            #1;
            if (bus.f_rsp_vld_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || (cyc - t0) != 3 || bus.rsp_err_o !== 1'b0 || bus.f_rsp_data_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL resume_response: got vld=%b latency=%0d err=%b data=%h expected 1 3 0 12345678",
                     got, cyc - t0, bus.rsp_err_o, bus.f_rsp_data_o);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        cur_lat = 3;
        tick();
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h0100_00C0;
        #1;
        checks++;
        if (bus.d_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_grant: got %b expected 1", bus.d_gnt_o);
        end
        tick();
        bus.d_req_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_read_en_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_read_active: got %b expected 1", bus.mem_read_en_o);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy_o, bus.mem_read_en_o, bus.mem_write_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_idle: got busy/rd/wr=%b expected 000",
                     {bus.busy_o, bus.mem_read_en_o, bus.mem_write_en_o});
        end
        seen = bus.f_rsp_vld_o | bus.d_rsp_vld_o;
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            if (bus.f_rsp_vld_o || bus.d_rsp_vld_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midreset_no_response: got a response expected none");
        end
    endtask

    task automatic test_random(input int n);
        logic          f_hold, d_hold, d_we;
        logic [AW-1:0] f_a, d_a, acc_addr;
        logic [DW-1:0] d_wd, acc_wdata, acc_rdata;
        logic          acc_read, acc_d, acc_err, in_acc, rsp_now, ef, ed;
        int            streak, free_at, acc_start, acc_resp, lat;
        do_reset();
        ref_mem.delete();
        mem_arr.delete();
        f_hold = 1'b0; d_hold = 1'b0; d_we = 1'b0;
        f_a = '0; d_a = '0; d_wd = '0;
        acc_addr = '0; acc_wdata = '0; acc_rdata = '0;
        acc_read = 1'b0; acc_d = 1'b0; acc_err = 1'b0;
        streak = 0; free_at = 0; acc_start = -10; acc_resp = -10;
        for (int i = 0; i < n; i++) begin
            tick();
            // Requesters: raise at random, hold until granted, occasionally give up
            if (!f_hold) begin
                if ($urandom_range(0, 99) < 45) begin
                    f_hold = 1'b1;
                    f_a = rand_addr();
                end
            end else if ($urandom_range(0, 99) < 4) begin
                f_hold = 1'b0;
            end
            if (!d_hold) begin
                if ($urandom_range(0, 99) < 45) begin
                    d_hold = 1'b1;
                    d_we = 1'($urandom_range(0, 1));
                    d_a = rand_addr();
                    d_wd = DW'($urandom);
                end
            end else if ($urandom_range(0, 99) < 4) begin
                d_hold = 1'b0;
            end
            bus.f_req_i   = f_hold;
            bus.f_addr_i  = f_a;
            bus.d_req_i   = d_hold;
            bus.d_we_i    = d_we;
            bus.d_addr_i  = d_a;
            bus.d_wdata_i = d_wd;
            #1;

            // Outstanding transaction: access window and response cycle
            in_acc  = (cyc >= acc_start) && (cyc < acc_resp);
            rsp_now = (cyc == acc_resp);
            checks++;
            if ({bus.f_rsp_vld_o, bus.d_rsp_vld_o, bus.rsp_err_o} !==
                {rsp_now && !acc_d, rsp_now && acc_d, rsp_now && acc_err}) begin
                errors++;
                $display("FAIL rand_rsp cycle %0d: got f/d/err=%b expected %b", cyc,
                         {bus.f_rsp_vld_o, bus.d_rsp_vld_o, bus.rsp_err_o},
                         {rsp_now && !acc_d, rsp_now && acc_d, rsp_now && acc_err});
            end
            if (rsp_now) begin
                checks++;
                if ((acc_d ? bus.d_rsp_data_o : bus.f_rsp_data_o) !== acc_rdata) begin
                    errors++;
                    $display("FAIL rand_rsp_data cycle %0d: got %h expected %h", cyc,
                             acc_d ? bus.d_rsp_data_o : bus.f_rsp_data_o, acc_rdata);
                end
            end
            checks++;
            if ({bus.mem_read_en_o, bus.mem_write_en_o, bus.busy_o, bus.mem_addr_o, bus.mem_data_o} !==
                {in_acc && acc_read, in_acc && !acc_read, in_acc,
                 in_acc ? acc_addr : AW'(0), in_acc ? acc_wdata : DW'(0)}) begin
                errors++;
                $display("FAIL rand_mem cycle %0d: got rd/wr/busy=%b addr=%h data=%h expected %b %h %h", cyc,
                         {bus.mem_read_en_o, bus.mem_write_en_o, bus.busy_o}, bus.mem_addr_o, bus.mem_data_o,
                         {in_acc && acc_read, in_acc && !acc_read, in_acc},
                         in_acc ? acc_addr : AW'(0), in_acc ? acc_wdata : DW'(0));
            end

            // Arbitration happens only once the previous access has completed
            ef = 1'b0;
            ed = 1'b0;
            if (cyc >= free_at) begin
                if (!f_hold) streak = 0;
                if (d_hold && (!f_hold || streak != int'(MAXS))) ed = 1'b1;
                else if (f_hold) ef = 1'b1;
                if (ef) streak = 0;
                else if (ed && f_hold && streak < int'(MAXS)) streak++;
            end
            checks++;
            if ({bus.f_gnt_o, bus.d_gnt_o} !== {ef, ed}) begin
                errors++;
                $display("FAIL rand_grant cycle %0d: got f/d=%b expected %b", cyc,
                         {bus.f_gnt_o, bus.d_gnt_o}, {ef, ed});
            end

            if (ef || ed) begin
                lat       = pick_lat();
                cur_lat   = lat;
                acc_d     = ed;
                acc_start = cyc + 1;
                acc_addr  = ed ? d_a : f_a;
                acc_wdata = ed ? d_wd : DW'(0);
                acc_read  = !(ed && d_we);
                if (!acc_read) begin
                    acc_resp  = cyc + 2;
                    acc_rdata = '0;
                    acc_err   = 1'b0;
                    ref_mem[acc_addr] = d_wd;
                end else if (lat <= int'(TO) - 1) begin
                    acc_resp  = cyc + 2 + lat;
                    acc_rdata = ref_rd(acc_addr);
                    acc_err   = 1'b0;
                end else begin
                    acc_resp  = cyc + 1 + int'(TO);
                    acc_rdata = '0;
                    acc_err   = 1'b1;
                end
                free_at = acc_resp;
                if (ef) f_hold = 1'b0;
                if (ed) d_hold = 1'b0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.mem_data_i     = '0;
        bus.mem_data_vld_i = 1'b0;
        rst = 1'b0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_timeout();
        test_mid_reset();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer. Shares one `memory` instance between the instruction-fetch requester and the load/store data requester. Each access runs through a grant → access → response sequence. Data accesses have priority, and a streak limit prevents fetch starvation. The block sits between `fetch`/the LSU path and the memory, replacing the fixed read-only, PC-addressed hookup.

## Interface
Parameters:
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width
- `MAX_D_STREAK`, 4, max consecutive data grants while a fetch request waits (≥1)
- `TIMEOUT`, 16, max cycles in ACCESS waiting for `mem_data_vld_i` on a read (≥2)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset
- `f_req_i`  in  1  fetch request, held until granted
- `f_addr_i`  in  AWIDTH  fetch address
- `f_gnt_o`  out  1  fetch grant, one-cycle pulse, combinational
- `f_rsp_vld_o`  out  1  fetch response valid, one-cycle pulse
- `f_rsp_data_o`  out  DWIDTH  fetched instruction
- `d_req_i`  in  1  data request, held until granted
- `d_we_i`  in  1  1 = store, 0 = load
- `d_addr_i`  in  AWIDTH  data address
- `d_wdata_i`  in  DWIDTH  store data
- `d_gnt_o`  out  1  data grant pulse, combinational
- `d_rsp_vld_o`  out  1  data response valid pulse (load data or store ack)
- `d_rsp_data_o`  out  DWIDTH  load data; 0 for store ack
- `rsp_err_o`  out  1  qualifies either `rsp_vld`: access timed out
- `mem_addr_o`  out  AWIDTH  to memory `addr_i`
- `mem_data_o`  out  DWIDTH  to memory `data_i`
- `mem_read_en_o`  out  1  to memory `read_en_i`
- `mem_write_en_o`  out  1  to memory `write_en_i`
- `mem_data_i`  in  DWIDTH  from memory `data_o`
- `mem_data_vld_i`  in  1  from memory `data_vld_o`
- `busy_o`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS.
- **Arbitration in IDLE:**
  - Only `d_req_i`: grant data.
  - Only `f_req_i`: grant fetch.
  - Both: grant data unless `streak == MAX_D_STREAK`, in which case grant fetch.
  - Exactly one grant per arbitration cycle; never both.
- **On grant:**
  - Latch owner, addr, we (0 for fetch), wdata into registers.
  - IDLE → ACCESS.
- **Streak counter** (width `$clog2(MAX_D_STREAK+1)`):
  - Increments on a data grant while `f_req_i` = 1; saturates at `MAX_D_STREAK`.
  - Clears on any fetch grant, and when `f_req_i` = 0 during IDLE.
- **ACCESS:**
  - `mem_addr_o`/`mem_data_o` driven from latched registers.
  - Read: `mem_read_en_o` = 1, held until `mem_data_vld_i` = 1. Then capture `mem_data_i`, go to IDLE.
  - Write: `mem_write_en_o` = 1 for exactly one cycle, then IDLE; `mem_data_vld_i` is ignored.
- **Timeout:**
  - A cycle counter runs in ACCESS for reads.
  - If it reaches `TIMEOUT` without `mem_data_vld_i`, go to IDLE and respond with `rsp_err_o` = 1 and data 0.
- **Response:**
  - Registered. The owner's `*_rsp_vld_o` pulses for one cycle in the cycle after ACCESS exits.
  - `rsp_err_o` is valid only with a `rsp_vld` pulse; otherwise 0.
- **Outside ACCESS:** `mem_read_en_o` = `mem_write_en_o` = 0 and `mem_addr_o`/`mem_data_o` = 0.
- **Requester rules:**
  - A request dropped before its grant is legal and produces nothing.
  - Requests are not sampled in ACCESS; no grant is issued there.
- **Reset (`rst` = 0 at a clock edge, including mid-ACCESS):**
  - State → IDLE; streak and timeout counters → 0.
  - All outputs → 0, including the registered responses.
  - An in-flight transaction is dropped; no response is issued.

## Timing
- Grant is combinational in the request cycle T.
- ACCESS starts at T+1.
- Read with `mem_data_vld_i` at T+1+k (k ≥ 0): `rsp_vld` at T+2+k.
- Write: `mem_write_en_o` at T+1, `rsp_vld` at T+2.
- The response cycle is an IDLE cycle, so a new grant may coincide with `rsp_vld`. Peak throughput is one access per 2 cycles.
- Timeout read: `rsp_vld` + `rsp_err_o` at T+1+`TIMEOUT`.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles with both requests high → all outputs 0, no grants. Release → data granted first cycle.
- **Single fetch:** `f_addr_i` = 0x0100_0000, memory returns vld same cycle with 0x0000_0013 → `f_gnt_o` at T, `mem_read_en_o` at T+1, `f_rsp_vld_o` with 0x0000_0013 at T+2.
- **Store then load same address:** store 0xDEADBEEF to 0x0100_0040 → `mem_write_en_o` one cycle, `d_rsp_vld_o` with data 0. Following load → `d_rsp_data_o` = 0xDEADBEEF.
- **Contention starvation guard:** both requests held continuously, `MAX_D_STREAK` = 4 → grant order D,D,D,D,F,D,D,D,D,F. Never two grants in one cycle.
- **Timeout:** load with `mem_data_vld_i` held 0 → `d_rsp_vld_o` and `rsp_err_o` at T+17, data 0, then normal operation resumes.
- **Mid-access reset:** reset asserted at T+1 of a read → no `rsp_vld` ever for it, `busy_o` = 0 next cycle, memory enables 0.
